// File: rtl/fifo_async_circular.sv
// -----------------------------------------------------------------------------
// fifo_async_circular
//
// Single-clock circular-buffer FIFO. A DEPTH x WIDTH register array is
// addressed by wrapping write and read pointers. Read data is registered.
// The full and empty flags are decoded combinationally from the registered
// pointers.
//
// Each pointer is $clog2(DEPTH)+1 bits wide. The low bits address the array.
// The MSB is a wrap bit that toggles on every pass around the buffer:
//   empty : pointers identical
//   full  : wrap bits differ, address bits equal
//
// Parameters
//   DEPTH          number of entries (power of two, >= 2)
//   WIDTH          data word width in bits
//
// Ports
//   clk            sole clock, rising edge
//   nrst_in        asynchronous active-low reset (pointers, read data)
//   write_in       push request, accepted when full_out is 0
//   data_write_in  push data
//   read_in        pop request, accepted when empty_out is 0
//   data_read_out  registered pop data, holds until the next accepted pop
//   full_out       FIFO holds DEPTH entries
//   empty_out      FIFO holds no entries
//   count_out      occupancy wptr - rptr (0..DEPTH), present only when
//                  FIFO_ASYNC_CIRCULAR_COUNT_EN is defined
//
// Build option
//   FIFO_ASYNC_CIRCULAR_COUNT_EN  adds the count_out port and its logic.
//
// The storage array is not reset; its contents are undefined after reset.
// -----------------------------------------------------------------------------
module fifo_async_circular #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst_in,
  input  logic                       write_in,
  input  logic [WIDTH-1:0]           data_write_in,
  input  logic                       read_in,
  output logic [WIDTH-1:0]           data_read_out,
  output logic                       full_out,
`ifdef FIFO_ASYNC_CIRCULAR_COUNT_EN
  output logic                       empty_out,
  output logic [$clog2(DEPTH):0]     count_out
`else
  output logic                       empty_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_rdata;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;

  assign w_waddr = r_wptr[AW-1:0];
  assign w_raddr = r_rptr[AW-1:0];

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_waddr == w_raddr);

  // Both requests are qualified by the flags from before the edge. A
  // simultaneous push and pop therefore never target the same slot. When
  // the addresses are equal, the FIFO is either empty (pop blocked) or full
  // (push blocked).
  assign w_wr_en = write_in & ~w_full;
  assign w_rd_en = read_in  & ~w_empty;

  // Storage array: written only, never reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_waddr] <= data_write_in;
    end
  end

  // Pointer registers: each wraps naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // Registered read data: holds its value when no pop is accepted
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= r_mem[w_raddr];
    end
  end

  assign data_read_out = r_rdata;
  assign full_out      = w_full;
  assign empty_out     = w_empty;

`ifdef FIFO_ASYNC_CIRCULAR_COUNT_EN
  // Modular difference of the extended pointers gives 0..DEPTH directly
  assign count_out = r_wptr - r_rptr;
`endif

endmodule

// File: tb/tb_fifo_async_circular.sv
// -----------------------------------------------------------------------------
// tb_fifo_async_circular
//
// Directed bench for fifo_async_circular (DEPTH 16, WIDTH 8).
//
// The fill/drain pass runs from a table of {inputs, expected outputs}
// records. The multi-cycle corner cases are hand-written sequences. Their
// expectations come from a small queue model that the bench keeps itself.
// -----------------------------------------------------------------------------
module tb_fifo_async_circular;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk;
  logic             nrst_in;
  logic             write_in;
  logic [WIDTH-1:0] data_write_in;
  logic             read_in;
  logic [WIDTH-1:0] data_read_out;
  logic             full_out;
  logic             empty_out;
`ifdef FIFO_ASYNC_CIRCULAR_COUNT_EN
  logic [4:0]       count_out;
`endif

  fifo_async_circular #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk          (clk),
    .nrst_in      (nrst_in),
    .write_in     (write_in),
    .data_write_in(data_write_in),
    .read_in      (read_in),
    .data_read_out(data_read_out),
    .full_out     (full_out),
`ifdef FIFO_ASYNC_CIRCULAR_COUNT_EN
    .empty_out    (empty_out),
    .count_out    (count_out)
`else
    .empty_out    (empty_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of requests, updates the model against the pre-edge
  // state, and leaves time at posedge+1 for sampling.
  task automatic step(input logic wr, input logic rd, input logic [7:0] din);
    int occ;
    occ = q.size();
    write_in      = wr;
    read_in       = rd;
    data_write_in = din;
    @(posedge clk);
    if (rd && occ > 0) exp_dout = q.pop_front();
    if (wr && occ < DEPTH) q.push_back(din);
    #1;
    write_in = 1'b0;
    read_in  = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " dout"},  {24'd0, data_read_out}, {24'd0, exp_dout});
    chk({tag, " full"},  {31'd0, full_out},  {31'd0, (q.size() == DEPTH)});
    chk({tag, " empty"}, {31'd0, empty_out}, {31'd0, (q.size() == 0)});
`ifdef FIFO_ASYNC_CIRCULAR_COUNT_EN
    chk({tag, " count"}, {27'd0, count_out}, q.size());
`endif
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = 8'h00;
  endtask

  logic [7:0] fill_data [16];
  vec_t       vecs [34];

  initial begin
    fill_data = '{8'h10, 8'h01, 8'h91, 8'hab, 8'hba, 8'haf, 8'hfa, 8'h22,
                  8'h11, 8'h99, 8'h11, 8'h00, 8'h13, 8'hff, 8'h25, 8'h23};

    // Fill: 16 accepted writes, the 17th (0x55) dropped. Read data stays 0.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{wr: 1'b1, rd: 1'b0, din: fill_data[i], dout: 8'h00,
                  full: (i == 15), empty: 1'b0};
    vecs[16] = '{wr: 1'b1, rd: 1'b0, din: 8'h55, dout: 8'h00, full: 1'b1, empty: 1'b0};
    // Drain: words come back in order. The 17th read holds 0x23.
    for (int i = 0; i < 16; i++)
      vecs[17 + i] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, dout: fill_data[i],
                       full: 1'b0, empty: (i == 15)};
    vecs[33] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, dout: 8'h23, full: 1'b0, empty: 1'b1};

    nrst_in       = 1'b0;
    write_in      = 1'b0;
    read_in       = 1'b0;
    data_write_in = 8'h00;
    model_reset();

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("reset empty", {31'd0, empty_out}, 32'd1);
    chk("reset full",  {31'd0, full_out},  32'd0);
    chk("reset dout",  {24'd0, data_read_out}, 32'h00);
`ifdef FIFO_ASYNC_CIRCULAR_COUNT_EN
    chk("reset count", {27'd0, count_out}, 32'd0);
`endif
    @(negedge clk);
    nrst_in = 1'b1;

    // Table-driven fill/drain
    for (int i = 0; i < 34; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d dout", i),  {24'd0, data_read_out}, {24'd0, vecs[i].dout});
      chk($sformatf("vec%0d full", i),  {31'd0, full_out},  {31'd0, vecs[i].full});
      chk($sformatf("vec%0d empty", i), {31'd0, empty_out}, {31'd0, vecs[i].empty});
    end

    // Wrap-around: 10 in, 10 out, then 16 in with wrapped pointers
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    chk_model("wrap drained");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'h60 + 8'(i));
      if (i == 14 || i == 15) chk_model($sformatf("wrap fill%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk_model($sformatf("wrap read%0d", i));
    end

    // Simultaneous push/pop at 5 entries for 20 cycles
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'ha0 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'hc0 + 8'(i));
      chk_model($sformatf("simul%0d", i));
    end
    // Top up to full, then push+pop: pop taken, push dropped
    while (q.size() < DEPTH) step(1'b1, 1'b0, 8'h70 + 8'(q.size()));
    chk_model("pre full simul");
    step(1'b1, 1'b1, 8'hee);
    chk_model("full simul");
    // Drain to empty, checking order (0xee must not appear)
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk_model($sformatf("full drain%0d", i));
    end
    // Empty push+pop: push taken, pop dropped, read data held
    step(1'b1, 1'b1, 8'h5a);
    chk_model("empty simul");
    step(1'b0, 1'b1, 8'h00);
    chk_model("empty simul pop");
    chk("empty simul word", {24'd0, data_read_out}, 32'h5a);

    // Reset mid-operation at 8 entries, asserted between clock edges
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    chk_model("pre midreset");
    #3;
    nrst_in = 1'b0;
    model_reset();
    #1;
    chk("midreset empty", {31'd0, empty_out}, 32'd1);
    chk("midreset full",  {31'd0, full_out},  32'd0);
    chk("midreset dout",  {24'd0, data_read_out}, 32'h00);
    @(negedge clk);
    nrst_in = 1'b1;
    step(1'b1, 1'b0, 8'h3c);
    chk_model("post reset write");
    step(1'b0, 1'b1, 8'h00);
    chk_model("post reset read");
    chk("post reset word", {24'd0, data_read_out}, 32'h3c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
